// File: rtl/rob_multi.sv
// Multi-lane reorder buffer: in-order allocation and commit, out-of-order writeback,
// squash on committed redirect or external flush, and newest-writer operand lookup.
module rob_multi #(
  parameter int DEPTH    = 16,
  parameter int ALLOC_W  = 2,
  parameter int COMMIT_W = 2,
  parameter int WB_PORTS = 2,
  parameter int NUM_RS   = 4,
  parameter int XLEN     = 32,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         flush_i,
  input  logic [ALLOC_W-1:0]           alloc_valid_i,
  input  logic [ALLOC_W*XLEN-1:0]      alloc_pc_i,
  input  logic [ALLOC_W*5-1:0]         alloc_rd_i,
  input  logic [ALLOC_W-1:0]           alloc_we_i,
  output logic                         alloc_ready_o,
  output logic [ALLOC_W*IDX_W-1:0]     alloc_idx_o,
  input  logic [WB_PORTS-1:0]          wb_valid_i,
  input  logic [WB_PORTS*IDX_W-1:0]    wb_idx_i,
  input  logic [WB_PORTS*XLEN-1:0]     wb_result_i,
  input  logic [WB_PORTS-1:0]          wb_branch_taken_i,
  input  logic [WB_PORTS*XLEN-1:0]     wb_new_pc_i,
  input  logic [WB_PORTS-1:0]          wb_xcpt_i,
  output logic [COMMIT_W-1:0]          commit_valid_o,
  output logic [COMMIT_W*XLEN-1:0]     commit_pc_o,
  output logic [COMMIT_W*5-1:0]        commit_rd_o,
  output logic [COMMIT_W-1:0]          commit_we_o,
  output logic [COMMIT_W*XLEN-1:0]     commit_result_o,
  output logic                         redirect_o,
  output logic [XLEN-1:0]              redirect_pc_o,
  output logic                         redirect_xcpt_o,
  input  logic [NUM_RS*5-1:0]          rs_addr_i,
  output logic [NUM_RS-1:0]            rs_hit_o,
  output logic [NUM_RS*IDX_W-1:0]      rs_idx_o,
  output logic [NUM_RS-1:0]            rs_ready_o,
  output logic [NUM_RS*XLEN-1:0]       rs_data_o,
  output logic [IDX_W:0]               count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PW = IDX_W + 1;

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, count;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, we_q, we_d, br_q, br_d, xcpt_q, xcpt_d;
  logic [4:0]       rd_q  [DEPTH];
  logic [4:0]       rd_d  [DEPTH];
  logic [XLEN-1:0]  pc_q  [DEPTH];
  logic [XLEN-1:0]  pc_d  [DEPTH];
  logic [XLEN-1:0]  res_q [DEPTH];
  logic [XLEN-1:0]  res_d [DEPTH];
  logic [XLEN-1:0]  npc_q [DEPTH];
  logic [XLEN-1:0]  npc_d [DEPTH];
  logic [PW-1:0]    n_commit, n_alloc;
  logic             redirect;

  assign count         = tail_q - head_q;
  assign count_o       = count;
  assign full_o        = (count == PW'(DEPTH));
  assign empty_o       = (count == '0);
  assign redirect_o    = redirect;
  // Credit comes only from the registered count; same-cycle commits are not counted.
  assign alloc_ready_o = ((PW'(DEPTH) - count) >= PW'(ALLOC_W)) && !redirect && !flush_i;

  for (genvar k = 0; k < ALLOC_W; k++) begin : g_aidx
    assign alloc_idx_o[k*IDX_W +: IDX_W] = tail_q[IDX_W-1:0] + IDX_W'(k);
  end

  always_comb begin
    logic             stop;
    logic [IDX_W-1:0] e;
    stop            = 1'b0;
    e               = '0;
    commit_valid_o  = '0;
    commit_pc_o     = '0;
    commit_rd_o     = '0;
    commit_we_o     = '0;
    commit_result_o = '0;
    redirect        = 1'b0;
    redirect_pc_o   = '0;
    redirect_xcpt_o = 1'b0;
    n_commit        = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      e = head_q[IDX_W-1:0] + IDX_W'(j);
      if (!stop && valid_q[e] && done_q[e]) begin
        commit_valid_o[j]                = 1'b1;
        commit_pc_o[j*XLEN +: XLEN]      = pc_q[e];
        commit_rd_o[j*5 +: 5]            = rd_q[e];
        commit_we_o[j]                   = we_q[e];
        commit_result_o[j*XLEN +: XLEN]  = res_q[e];
        n_commit                         = n_commit + PW'(1);
        if (br_q[e] || xcpt_q[e]) begin
          redirect        = 1'b1;
          redirect_pc_o   = npc_q[e];
          redirect_xcpt_o = xcpt_q[e];
          stop            = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
    if (flush_i) begin
      commit_valid_o  = '0;
      redirect        = 1'b0;
      redirect_pc_o   = '0;
      redirect_xcpt_o = 1'b0;
      n_commit        = '0;
    end
  end

  // Valid entries always occupy [head, tail), so scanning by age offset leaves the newest match.
  always_comb begin
    logic [IDX_W-1:0] e;
    logic [4:0]       a;
    e          = '0;
    a          = '0;
    rs_hit_o   = '0;
    rs_idx_o   = '0;
    rs_ready_o = '0;
    rs_data_o  = '0;
    for (int r = 0; r < NUM_RS; r++) begin
      a = rs_addr_i[r*5 +: 5];
      for (int o = 0; o < DEPTH; o++) begin
        e = head_q[IDX_W-1:0] + IDX_W'(o);
        if (valid_q[e] && we_q[e] && (rd_q[e] == a) && (a != 5'd0)) begin
          rs_hit_o[r]                  = 1'b1;
          rs_idx_o[r*IDX_W +: IDX_W]   = e;
          rs_ready_o[r]                = done_q[e];
          rs_data_o[r*XLEN +: XLEN]    = res_q[e];
        end
      end
    end
  end

  always_comb begin
    logic [IDX_W-1:0] e;
    e       = '0;
    valid_d = valid_q;
    done_d  = done_q;
    we_d    = we_q;
    br_d    = br_q;
    xcpt_d  = xcpt_q;
    rd_d    = rd_q;
    pc_d    = pc_q;
    res_d   = res_q;
    npc_d   = npc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    n_alloc = '0;
    if (flush_i) begin
      valid_d = '0;
      tail_d  = head_q;
    end else if (redirect) begin
      valid_d = '0;
      head_d  = head_q + n_commit;
      tail_d  = head_q + n_commit;
    end else begin
      // Higher-numbered ports are applied last so they win on a shared index.
      for (int p = 0; p < WB_PORTS; p++) begin
        e = wb_idx_i[p*IDX_W +: IDX_W];
        if (wb_valid_i[p] && valid_q[e]) begin
          done_d[e] = 1'b1;
          res_d[e]  = wb_result_i[p*XLEN +: XLEN];
          npc_d[e]  = wb_new_pc_i[p*XLEN +: XLEN];
          br_d[e]   = wb_branch_taken_i[p];
          xcpt_d[e] = wb_xcpt_i[p];
        end
      end
      for (int j = 0; j < COMMIT_W; j++) begin
        if (commit_valid_o[j]) valid_d[head_q[IDX_W-1:0] + IDX_W'(j)] = 1'b0;
      end
      head_d = head_q + n_commit;
      if (alloc_ready_o) begin
        for (int k = 0; k < ALLOC_W; k++) begin
          if (alloc_valid_i[k]) begin
            e         = tail_q[IDX_W-1:0] + IDX_W'(k);
            valid_d[e] = 1'b1;
            done_d[e]  = 1'b0;
            br_d[e]    = 1'b0;
            xcpt_d[e]  = 1'b0;
            we_d[e]    = alloc_we_i[k];
            rd_d[e]    = alloc_rd_i[k*5 +: 5];
            pc_d[e]    = alloc_pc_i[k*XLEN +: XLEN];
            n_alloc    = n_alloc + PW'(1);
          end
        end
      end
      tail_d = tail_q + n_alloc;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
      we_q    <= '0;
      br_q    <= '0;
      xcpt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        pc_q[i]  <= '0;
        res_q[i] <= '0;
        npc_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      we_q    <= we_d;
      br_q    <= br_d;
      xcpt_q  <= xcpt_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
      res_q   <= res_d;
      npc_q   <= npc_d;
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
// Bench for rob_multi: directed scenarios plus random traffic, checked every cycle
// against a queue-level model of the reorder buffer.
module tb_rob_multi;
  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        flush_i;
  logic [1:0]  alloc_valid_i;
  logic [63:0] alloc_pc_i;
  logic [9:0]  alloc_rd_i;
  logic [1:0]  alloc_we_i;
  logic        alloc_ready_o;
  logic [7:0]  alloc_idx_o;
  logic [1:0]  wb_valid_i;
  logic [7:0]  wb_idx_i;
  logic [63:0] wb_result_i;
  logic [1:0]  wb_branch_taken_i;
  logic [63:0] wb_new_pc_i;
  logic [1:0]  wb_xcpt_i;
  logic [1:0]  commit_valid_o;
  logic [63:0] commit_pc_o;
  logic [9:0]  commit_rd_o;
  logic [1:0]  commit_we_o;
  logic [63:0] commit_result_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_xcpt_o;
  logic [19:0] rs_addr_i;
  logic [3:0]  rs_hit_o;
  logic [15:0] rs_idx_o;
  logic [3:0]  rs_ready_o;
  logic [127:0] rs_data_o;
  logic [4:0]  count_o;
  logic        full_o;
  logic        empty_o;

  rob_multi dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_pc_i(alloc_pc_i), .alloc_rd_i(alloc_rd_i),
    .alloc_we_i(alloc_we_i), .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_result_i(wb_result_i),
    .wb_branch_taken_i(wb_branch_taken_i), .wb_new_pc_i(wb_new_pc_i), .wb_xcpt_i(wb_xcpt_i),
    .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o), .commit_rd_o(commit_rd_o),
    .commit_we_o(commit_we_o), .commit_result_o(commit_result_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .redirect_xcpt_o(redirect_xcpt_o),
    .rs_addr_i(rs_addr_i), .rs_hit_o(rs_hit_o), .rs_idx_o(rs_idx_o), .rs_ready_o(rs_ready_o),
    .rs_data_o(rs_data_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic        done;
    logic        br;
    logic        xc;
    logic [31:0] res;
    logic [31:0] npc;
  } ent_t;

  ent_t q[$];
  int   head;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_n;
  bit   exp_redir;
  bit   exp_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flush_i = 1'b0; alloc_valid_i = '0; alloc_pc_i = '0; alloc_rd_i = '0; alloc_we_i = '0;
    wb_valid_i = '0; wb_idx_i = '0; wb_result_i = '0; wb_branch_taken_i = '0;
    wb_new_pc_i = '0; wb_xcpt_i = '0;
    rs_addr_i = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
  endtask

  task automatic set_lane(input int k, input int rd, input bit we);
    alloc_valid_i[k] = 1'b1;
    alloc_pc_i[k*32 +: 32] = $urandom;
    alloc_rd_i[k*5 +: 5] = 5'(rd);
    alloc_we_i[k] = we;
  endtask

  task automatic set_wb(input int p, input int idx, input logic [31:0] res,
                        input bit br, input bit xc, input logic [31:0] npc);
    wb_valid_i[p] = 1'b1;
    wb_idx_i[p*4 +: 4] = 4'(idx);
    wb_result_i[p*32 +: 32] = res;
    wb_branch_taken_i[p] = br;
    wb_xcpt_i[p] = xc;
    wb_new_pc_i[p*32 +: 32] = npc;
  endtask

  // Compare every output with the model's view of the current (pre-edge) cycle.
  task automatic sample();
    logic [1:0] cv;
    int         sz;
    #1;
    sz = q.size();
    exp_n = 0; exp_redir = 0; cv = '0;
    if (!flush_i) begin
      for (int j = 0; j < 2; j++) begin
        if (j >= sz || !q[j].done) break;
        cv[j] = 1'b1; exp_n++;
        if (q[j].br || q[j].xc) begin exp_redir = 1; break; end
      end
    end
    exp_ready = (DEPTH - sz >= 2) && !exp_redir && !flush_i;
    chk("count", 64'(count_o), 64'(sz));
    chk("full", 64'(full_o), 64'(sz == DEPTH));
    chk("empty", 64'(empty_o), 64'(sz == 0));
    chk("alloc_ready", 64'(alloc_ready_o), 64'(exp_ready));
    chk("alloc_idx0", 64'(alloc_idx_o[3:0]), 64'((head + sz) % DEPTH));
    chk("alloc_idx1", 64'(alloc_idx_o[7:4]), 64'((head + sz + 1) % DEPTH));
    chk("commit_valid", 64'(commit_valid_o), 64'(cv));
    for (int j = 0; j < exp_n; j++) begin
      chk("commit_pc", 64'(commit_pc_o[j*32 +: 32]), 64'(q[j].pc));
      chk("commit_rd", 64'(commit_rd_o[j*5 +: 5]), 64'(q[j].rd));
      chk("commit_we", 64'(commit_we_o[j]), 64'(q[j].we));
      chk("commit_res", 64'(commit_result_o[j*32 +: 32]), 64'(q[j].res));
    end
    chk("redirect", 64'(redirect_o), 64'(exp_redir));
    if (exp_redir) begin
      chk("redirect_pc", 64'(redirect_pc_o), 64'(q[exp_n-1].npc));
      chk("redirect_xcpt", 64'(redirect_xcpt_o), 64'(q[exp_n-1].xc));
    end
    for (int r = 0; r < 4; r++) begin
      int         hit_i;
      logic [4:0] a;
      a = rs_addr_i[r*5 +: 5];
      hit_i = -1;
      if (a != 0) begin
        for (int i = sz - 1; i >= 0; i--) begin
          if (q[i].we && q[i].rd == a) begin hit_i = i; break; end
        end
      end
      chk("rs_hit", 64'(rs_hit_o[r]), 64'(hit_i >= 0));
      if (hit_i >= 0) begin
        chk("rs_idx", 64'(rs_idx_o[r*4 +: 4]), 64'((head + hit_i) % DEPTH));
        chk("rs_ready", 64'(rs_ready_o[r]), 64'(q[hit_i].done));
        if (q[hit_i].done) chk("rs_data", 64'(rs_data_o[r*32 +: 32]), 64'(q[hit_i].res));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (flush_i) begin
      q.delete();
    end else if (exp_redir) begin
      head = (head + exp_n) % DEPTH;
      q.delete();
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wb_valid_i[p]) begin
          int off;
          off = (int'(wb_idx_i[p*4 +: 4]) - head + DEPTH) % DEPTH;
          if (off < q.size()) begin
            q[off].done = 1'b1;
            q[off].res  = wb_result_i[p*32 +: 32];
            q[off].npc  = wb_new_pc_i[p*32 +: 32];
            q[off].br   = wb_branch_taken_i[p];
            q[off].xc   = wb_xcpt_i[p];
          end
        end
      end
      for (int j = 0; j < exp_n; j++) void'(q.pop_front());
      head = (head + exp_n) % DEPTH;
      if (exp_ready) begin
        for (int k = 0; k < 2; k++) begin
          if (alloc_valid_i[k]) begin
            ent_t e;
            e.pc = alloc_pc_i[k*32 +: 32]; e.rd = alloc_rd_i[k*5 +: 5]; e.we = alloc_we_i[k];
            e.done = 0; e.br = 0; e.xc = 0; e.res = '0; e.npc = '0;
            q.push_back(e);
          end
        end
      end
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic cyc();
    sample();
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rstn_i = 1'b0;
    clear_inputs();
    #1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_ready", 64'(alloc_ready_o), 64'd1);
    chk("rst_commit", 64'(commit_valid_o), 64'd0);
    chk("rst_redirect", 64'(redirect_o), 64'd0);
    chk("rst_hit", 64'(rs_hit_o), 64'd0);
    q.delete();
    head = 0;
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic fill_pairs(input int n);
    for (int c = 0; c < n; c++) begin
      set_lane(0, $urandom_range(1, 7), 1'($urandom_range(0, 1)));
      set_lane(1, $urandom_range(1, 7), 1'($urandom_range(0, 1)));
      cyc();
    end
  endtask

  initial begin
    rstn_i = 1'b0;
    clear_inputs();
    do_reset();

    // Fill to DEPTH, dropped request while full, then retire two.
    fill_pairs(8);
    set_lane(0, 1, 1); set_lane(1, 2, 1);
    sample();
    chk("t1_full", 64'(full_o), 64'd1);
    chk("t1_count", 64'(count_o), 64'd16);
    chk("t1_ready", 64'(alloc_ready_o), 64'd0);
    tick();
    set_wb(0, 0, 32'h11, 0, 0, 0); set_wb(1, 1, 32'h22, 0, 0, 0);
    cyc();
    sample();
    chk("t1_commit", 64'(commit_valid_o), 64'b11);
    tick();
    sample();
    chk("t1_count14", 64'(count_o), 64'd14);
    tick();

    // Out-of-order completion held back by an incomplete head; mid-operation reset.
    do_reset();
    fill_pairs(7);
    set_wb(0, 2, 32'h2, 0, 0, 0); set_wb(1, 3, 32'h3, 0, 0, 0);
    cyc();
    set_wb(0, 0, 32'h0, 0, 0, 0);
    sample();
    chk("t2_none", 64'(commit_valid_o), 64'b00);
    tick();
    set_wb(0, 1, 32'h1, 0, 0, 0);
    sample();
    chk("t2_lane0", 64'(commit_valid_o), 64'b01);
    tick();
    sample();
    chk("t2_both", 64'(commit_valid_o), 64'b11);
    chk("t2_res1", 64'(commit_result_o[63:32]), 64'h2);
    tick();

    // Committed taken branch squashes the younger entries.
    do_reset();
    fill_pairs(3);
    set_wb(0, 2, 32'h2, 0, 0, 0); set_wb(1, 3, 32'h3, 0, 0, 0); cyc();
    set_wb(0, 4, 32'h4, 0, 0, 0); set_wb(1, 5, 32'h5, 0, 0, 0); cyc();
    set_wb(0, 0, 32'h0, 0, 0, 0); set_wb(1, 1, 32'h1, 1, 0, 32'h80); cyc();
    sample();
    chk("t3_commit", 64'(commit_valid_o), 64'b11);
    chk("t3_redirect", 64'(redirect_o), 64'd1);
    chk("t3_rpc", 64'(redirect_pc_o), 64'h80);
    tick();
    sample();
    chk("t3_empty", 64'(empty_o), 64'd1);
    chk("t3_tail", 64'(alloc_idx_o[3:0]), 64'd2);
    tick();

    // Random traffic across pointer wrap, then fill to full and drain to empty.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int n;
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) set_lane(k, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      for (int p = 0; p < 2; p++) begin
        if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
          int i;
          i = $urandom_range(0, q.size() - 1);
          set_wb(p, (head + i) % DEPTH, $urandom, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0), $urandom);
        end
      end
      cyc();
    end
    fill_pairs(10);
    sample();
    chk("t4_full", 64'(full_o), 64'd1);
    tick();
    for (int it = 0; it < 20; it++) begin
      int p;
      p = 0;
      for (int i = 0; i < q.size() && p < 2; i++) begin
        if (!q[i].done) begin set_wb(p, (head + i) % DEPTH, $urandom, 0, 0, 0); p++; end
      end
      cyc();
    end
    sample();
    chk("t4_empty", 64'(empty_o), 64'd1);
    tick();

    // Newest writer lookup.
    do_reset();
    set_lane(0, 2, 1); set_lane(1, 2, 1); cyc();
    set_lane(0, 2, 1); set_lane(1, 7, 1); cyc();
    set_lane(0, 2, 1); set_lane(1, 7, 1); cyc();
    set_wb(0, 5, 32'hDEAD, 0, 0, 0); cyc();
    rs_addr_i[4:0] = 5'd7; rs_addr_i[9:5] = 5'd0;
    sample();
    chk("t5_hit", 64'(rs_hit_o[0]), 64'd1);
    chk("t5_idx", 64'(rs_idx_o[3:0]), 64'd5);
    chk("t5_ready", 64'(rs_ready_o[0]), 64'd1);
    chk("t5_data", 64'(rs_data_o[31:0]), 64'hDEAD);
    chk("t5_x0", 64'(rs_hit_o[1]), 64'd0);
    tick();

    // Flush beats commit and writeback.
    do_reset();
    fill_pairs(3);
    set_wb(0, 0, 32'h10, 0, 0, 0); set_wb(1, 1, 32'h11, 0, 0, 0); cyc();
    flush_i = 1'b1;
    set_wb(0, 4, 32'h40, 0, 0, 0); set_wb(1, 4, 32'h41, 0, 0, 0);
    sample();
    chk("t6_nocommit", 64'(commit_valid_o), 64'd0);
    tick();
    sample();
    chk("t6_empty", 64'(empty_o), 64'd1);
    tick();

    // Same-index writeback: the higher port wins.
    do_reset();
    set_lane(0, 1, 1); set_lane(1, 1, 1); cyc();
    set_lane(0, 1, 1); set_lane(1, 1, 1); cyc();
    set_lane(0, 9, 1); set_lane(1, 10, 1); cyc();
    set_wb(0, 4, 32'hAAAA, 0, 0, 0); set_wb(1, 4, 32'hBBBB, 0, 0, 0); cyc();
    rs_addr_i[4:0] = 5'd9;
    sample();
    chk("t7_hit", 64'(rs_hit_o[0]), 64'd1);
    chk("t7_data", 64'(rs_data_o[31:0]), 64'hBBBB);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
